timer_sequencer: RTL and testbench
==================================

TIMER_SEQUENCER -- requirements
Module: timer_sequencer

Interface
REQ-001 Parameter: TICK_W, default 16, width of the tick counter output.
REQ-002 Port: clk  in  1  sole clock; all logic on rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: start  in  1  one-cycle request to program and start the timer; sampled only in IDLE.
REQ-005 Port: stop  in  1  one-cycle request to halt a running timer; sampled only in RUN.
REQ-006 Port: period  in  32  timer load value; captured on accepted start.
REQ-007 Port: continuous  in  1  run mode; captured on accepted start. 1 = periodic, 0 = single-shot.
REQ-008 Port: address  out  3  Avalon-MM address to the timer slave.
REQ-009 Port: chipselect  out  1  Avalon-MM select.
REQ-010 Port: write_n  out  1  Avalon-MM write strobe, active-low.
REQ-011 Port: writedata  out  16  Avalon-MM write data.
REQ-012 Port: readdata  in  16  Avalon-MM read data; registered by the slave; valid the cycle after the address is presented.
REQ-013 Port: irq  in  1  timer interrupt (timeout latched AND interrupt enable).
REQ-014 Port: busy  out  1  high in every state except IDLE.
REQ-015 Port: tick  out  1  one-cycle pulse per serviced timeout.
REQ-016 Port: tick_count  out  TICK_W  serviced timeouts since last accepted start.
REQ-017 Port: done  out  1  one-cycle pulse on the return to IDLE.
REQ-018 Port: final_running  out  1  status bit 1 (running) read back at the end of the sequence.

Function
REQ-019 States: IDLE, WR_PL, WR_PH, WR_CTL, RUN, CLR, WR_STOP, RD_STS, RD_CAP. One state per cycle, except RUN, which holds.
REQ-020 Bus idle value (all states except those listed below): chipselect=0, write_n=1, address=0, writedata=0.
REQ-021 IDLE + start=1: capture period and continuous, clear tick_count to 0, go to WR_PL.
REQ-022 WR_PL: write address 2, data period[15:0]. Go to WR_PH.
REQ-023 WR_PH: write address 3, data period[31:16]. Go to WR_CTL.
REQ-024 WR_CTL: write address 1, data 0x0005 | (continuous<<1), i.e. START + ITO + CONT. Go to RUN.
REQ-025 RUN with irq=1: go to CLR. Else RUN with stop=1: go to WR_STOP. Else hold. irq takes priority over stop in the same cycle.
REQ-026 CLR: write address 0, data 0x0000 (clears timeout). Pulse tick. tick_count increments modulo 2^TICK_W (wraps, no saturation).
REQ-027 CLR exit: if continuous=1, go to RUN (irq is low in that next cycle). Else go to WR_STOP.
REQ-028 stop asserted during CLR: registered as a pending stop. RUN acts on it on the following cycle. Pending stop is cleared on WR_STOP.
REQ-029 WR_STOP: write address 1, data 0x0008 (STOP; ITO and CONT cleared). Go to RD_STS.
REQ-030 RD_STS: chipselect=1, write_n=1, address 0. Go to RD_CAP.
REQ-031 RD_CAP: final_running <= readdata[1]. Pulse done. Go to IDLE.
REQ-032 start outside IDLE and stop outside RUN/CLR are ignored (no queuing).
REQ-033 period is passed unmodified, including 0 and 0xFFFFFFFF. No range checks.
REQ-034 A timeout coinciding with the CLR write is lost by the slave. This is accepted behaviour; no compensation.

Reset
REQ-035 reset=1 at a clock edge forces IDLE from any state, including mid-write or RUN.
REQ-036 Reset values: address=0, chipselect=0, write_n=1, writedata=0, busy=0, tick=0, tick_count=0, done=0, final_running=0, pending stop=0, captured period=0, captured continuous=0.
REQ-037 No bus access is issued in the cycle reset is asserted; the first legal start is the cycle after reset deasserts.

Verification
REQ-038 Start, period=0x0001_86A0, continuous=1 -> exact write sequence: (2,0x86A0), (3,0x0001), (1,0x0007) on consecutive cycles; busy=1 from the next cycle.
REQ-039 Continuous run with slave model, period=9 -> tick every 10-cycle slave period plus service; 5 irqs -> tick_count=5, each serviced by (0,0x0000) write.
REQ-040 Single-shot, period=4 -> writes (1,0x0005), one irq -> tick, (0,0x0000), (1,0x0008), read addr 0 -> final_running=0, done pulse, tick_count=1.
REQ-041 stop pulse in RUN with no irq -> (1,0x0008) next cycle, read, done. irq and stop same cycle -> CLR first, then WR_STOP.
REQ-042 TICK_W=2, continuous run, 5 irqs -> tick_count sequence 1,2,3,0,1.
REQ-043 reset asserted during WR_PH and during RUN -> next cycle IDLE with all REQ-036 values. A start asserted while busy produces no extra writes.

Source files
------------

// File: rtl/timer_sequencer_if.sv
// Avalon-MM master-side bundle between the timer sequencer and an interval-timer slave.
// The slave's interrupt line travels with the bus.
interface timer_sequencer_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata,
        input  irq
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata,
        output irq
    );
endinterface

// File: rtl/timer_sequencer.sv
// Programs an Avalon interval timer, services its timeouts, stops it and reads back status.
// All bus signals and status outputs are registered; they are set on the edge that enters a state.
module timer_sequencer #(
    parameter int unsigned TICK_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic [31:0]         period,
    input  logic                continuous,
    timer_sequencer_if.master   bus,
    output logic                busy,
    output logic                tick,
    output logic [TICK_W-1:0]   tick_count,
    output logic                done,
    output logic                final_running
);

    localparam logic [2:0]  AddrStatus  = 3'd0;
    localparam logic [2:0]  AddrControl = 3'd1;
    localparam logic [2:0]  AddrPeriodL = 3'd2;
    localparam logic [2:0]  AddrPeriodH = 3'd3;

    localparam logic [15:0] CtlIto   = 16'h0001;
    localparam logic [15:0] CtlCont  = 16'h0002;
    localparam logic [15:0] CtlStart = 16'h0004;
    localparam logic [15:0] CtlStop  = 16'h0008;

    typedef enum logic [3:0] {
        StIdle,
        StWrPl,
        StWrPh,
        StWrCtl,
        StRun,
        StClr,
        StWrStop,
        StRdSts,
        StRdCap
    } state_e;

    state_e              state_q;
    logic [31:0]         period_q;
    logic                cont_q;
    logic                stop_pend_q;
    logic [2:0]          addr_q;
    logic                cs_q;
    logic                wr_n_q;
    logic [15:0]         wdata_q;
    logic                busy_q;
    logic                tick_q;
    logic [TICK_W-1:0]   tick_count_q;
    logic                done_q;
    logic                final_running_q;

    // Only the RUN status bit is consumed.
    logic unused_readdata;
    assign unused_readdata = ^{bus.readdata[15:2], bus.readdata[0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            period_q        <= '0;
            cont_q          <= 1'b0;
            stop_pend_q     <= 1'b0;
            addr_q          <= '0;
            cs_q            <= 1'b0;
            wr_n_q          <= 1'b1;
            wdata_q         <= '0;
            busy_q          <= 1'b0;
            tick_q          <= 1'b0;
            tick_count_q    <= '0;
            done_q          <= 1'b0;
            final_running_q <= 1'b0;
        end else begin
            // Bus idles and pulses drop unless the target state overrides below.
            addr_q  <= '0;
            cs_q    <= 1'b0;
            wr_n_q  <= 1'b1;
            wdata_q <= '0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        period_q     <= period;
                        cont_q       <= continuous;
                        tick_count_q <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= StWrPl;
                        cs_q         <= 1'b1;
                        wr_n_q       <= 1'b0;
                        addr_q       <= AddrPeriodL;
                        wdata_q      <= period[15:0];
                    end
                end

                StWrPl: begin
                    state_q <= StWrPh;
                    cs_q    <= 1'b1;
                    wr_n_q  <= 1'b0;
                    addr_q  <= AddrPeriodH;
                    wdata_q <= period_q[31:16];
                end

                StWrPh: begin
                    state_q <= StWrCtl;
                    cs_q    <= 1'b1;
                    wr_n_q  <= 1'b0;
                    addr_q  <= AddrControl;
                    wdata_q <= CtlStart | CtlIto | (cont_q ? CtlCont : 16'h0000);
                end

                StWrCtl: begin
                    state_q <= StRun;
                end

                StRun: begin
                    if (bus.irq) begin
                        // A stop that loses to irq is remembered and honoured after service.
                        if (stop) begin
                            stop_pend_q <= 1'b1;
                        end
                        state_q      <= StClr;
                        tick_q       <= 1'b1;
                        tick_count_q <= tick_count_q + TICK_W'(1);
                        cs_q         <= 1'b1;
                        wr_n_q       <= 1'b0;
                        addr_q       <= AddrStatus;
                        wdata_q      <= 16'h0000;
                    end else if (stop || stop_pend_q) begin
                        state_q <= StWrStop;
                        cs_q    <= 1'b1;
                        wr_n_q  <= 1'b0;
                        addr_q  <= AddrControl;
                        wdata_q <= CtlStop;
                    end
                end

                StClr: begin
                    if (stop) begin
                        stop_pend_q <= 1'b1;
                    end
                    if (cont_q) begin
                        state_q <= StRun;
                    end else begin
                        state_q <= StWrStop;
                        cs_q    <= 1'b1;
                        wr_n_q  <= 1'b0;
                        addr_q  <= AddrControl;
                        wdata_q <= CtlStop;
                    end
                end

                StWrStop: begin
                    stop_pend_q <= 1'b0;
                    state_q     <= StRdSts;
                    cs_q        <= 1'b1;
                    addr_q      <= AddrStatus;
                end

                StRdSts: begin
                    state_q <= StRdCap;
                end

                StRdCap: begin
                    // Slave registers readdata, so it is valid now, one cycle after the address.
                    final_running_q <= bus.readdata[1];
                    done_q          <= 1'b1;
                    busy_q          <= 1'b0;
                    state_q         <= StIdle;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.address    = addr_q;
    assign bus.chipselect = cs_q;
    assign bus.write_n    = wr_n_q;
    assign bus.writedata  = wdata_q;

    assign busy           = busy_q;
    assign tick           = tick_q;
    assign tick_count     = tick_count_q;
    assign done           = done_q;
    assign final_running  = final_running_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed bench for timer_sequencer: bus write log, small interval-timer slave model,
// and a second instance with a 2-bit tick counter to exercise wrap-around.
module tb_timer_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stop;
    logic [31:0] period;
    logic        continuous;
    logic        busy;
    logic        tick;
    logic [15:0] tick_count;
    logic        done;
    logic        final_running;

    logic        start2;
    logic        stop2;
    logic        busy2;
    logic        tick2;
    logic [1:0]  tick_count2;
    logic        done2;
    logic        final_running2;
    logic        irq2_drv;

    logic        use_model;
    logic        irq_drv;
    logic [15:0] rd_drv;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;

    logic [18:0] wr_log[$];
    logic [18:0] exp_q[$];
    int          tick_times[$];

    logic [1:0]  exp_tw2 [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    timer_sequencer_if bus ();
    timer_sequencer_if bus2 ();

    timer_sequencer #(.TICK_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .stop          (stop),
        .period        (period),
        .continuous    (continuous),
        .bus           (bus),
        .busy          (busy),
        .tick          (tick),
        .tick_count    (tick_count),
        .done          (done),
        .final_running (final_running)
    );

    timer_sequencer #(.TICK_W(2)) dut2 (
        .clk           (clk),
        .reset         (reset),
        .start         (start2),
        .stop          (stop2),
        .period        (period),
        .continuous    (continuous),
        .bus           (bus2),
        .busy          (busy2),
        .tick          (tick2),
        .tick_count    (tick_count2),
        .done          (done2),
        .final_running (final_running2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Interval-timer slave: counts period..0 then latches timeout; status write clears it.
    logic [31:0] m_period;
    logic [31:0] m_count;
    logic        m_to;
    logic        m_run;
    logic        m_ito;
    logic        m_cont;
    logic [15:0] m_rd;
    logic        m_tmo;
    logic        m_wr;

    assign m_tmo = m_run && (m_count == 32'd0);
    assign m_wr  = bus.chipselect && !bus.write_n;

    always @(posedge clk) begin
        if (reset) begin
            m_period <= '0;
            m_count  <= '0;
            m_to     <= 1'b0;
            m_run    <= 1'b0;
            m_ito    <= 1'b0;
            m_cont   <= 1'b0;
            m_rd     <= '0;
        end else begin
            if (m_run) m_count <= (m_count == 32'd0) ? m_period : m_count - 32'd1;
            if (m_tmo && !m_cont) m_run <= 1'b0;
            if (m_wr && bus.address == 3'd0) m_to <= 1'b0;
            else if (m_tmo) m_to <= 1'b1;
            if (m_wr && bus.address == 3'd2) m_period[15:0] <= bus.writedata;
            if (m_wr && bus.address == 3'd3) m_period[31:16] <= bus.writedata;
            if (m_wr && bus.address == 3'd1) begin
                m_ito  <= bus.writedata[0];
                m_cont <= bus.writedata[1];
                if (bus.writedata[2]) begin
                    m_run   <= 1'b1;
                    m_count <= m_period;
                end
                if (bus.writedata[3]) m_run <= 1'b0;
            end
            m_rd <= {14'd0, m_run, m_to};
        end
    end

    assign bus.irq       = use_model ? (m_to && m_ito) : irq_drv;
    assign bus.readdata  = use_model ? m_rd : rd_drv;
    assign bus2.irq      = irq2_drv;
    assign bus2.readdata = 16'h0000;

    always @(negedge clk) begin
        if (!reset && bus.chipselect && !bus.write_n) wr_log.push_back({bus.address, bus.writedata});
        if (!reset && tick) tick_times.push_back(cyc);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bus(input string tag, input logic cs, input logic wn,
                             input logic [2:0] addr, input logic [15:0] data);
        check_eq({tag, "_cs"}, bus.chipselect, cs);
        check_eq({tag, "_wn"}, bus.write_n, wn);
        check_eq({tag, "_addr"}, bus.address, addr);
        check_eq({tag, "_data"}, bus.writedata, data);
    endtask

    task automatic exp_wr(input logic [2:0] a, input logic [15:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic compare_log(input string tag);
        check_eq({tag, "_len"}, wr_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < wr_log.size()) check_eq(tag, {13'd0, wr_log[i]}, {13'd0, exp_q[i]});
        end
        wr_log.delete();
        exp_q.delete();
    endtask

    task automatic launch(input logic [31:0] p, input logic c);
        period     = p;
        continuous = c;
        start      = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int n = 0; n < 400 && !seen; n++) begin
            step();
            if (done) seen = 1'b1;
        end
        check_eq(tag, seen, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        stop       = 1'b0;
        period     = '0;
        continuous = 1'b0;
        start2     = 1'b0;
        stop2      = 1'b0;
        irq2_drv   = 1'b0;
        use_model  = 1'b0;
        irq_drv    = 1'b0;
        rd_drv     = '0;
        step();
        step();

        // Reset values
        check_bus("rst", 1'b0, 1'b1, 3'd0, 16'h0000);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_tick", tick, 1'b0);
        check_eq("rst_count", tick_count, 16'd0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_final", final_running, 1'b0);
        reset = 1'b0;

        // Programming sequence, one service, stop, status read
        period     = 32'h0001_86A0;
        continuous = 1'b1;
        start      = 1'b1;
        step();
        start = 1'b0;
        check_bus("prog_pl", 1'b1, 1'b0, 3'd2, 16'h86A0);
        check_eq("prog_busy", busy, 1'b1);
        step();
        check_bus("prog_ph", 1'b1, 1'b0, 3'd3, 16'h0001);
        step();
        check_bus("prog_ctl", 1'b1, 1'b0, 3'd1, 16'h0007);
        step();
        check_bus("run_idle", 1'b0, 1'b1, 3'd0, 16'h0000);
        irq_drv = 1'b1;
        step();
        irq_drv = 1'b0;
        check_bus("clr", 1'b1, 1'b0, 3'd0, 16'h0000);
        check_eq("clr_tick", tick, 1'b1);
        check_eq("clr_count", tick_count, 16'd1);
        step();
        check_eq("run_tick_low", tick, 1'b0);
        check_eq("run_cs", bus.chipselect, 1'b0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_bus("wr_stop", 1'b1, 1'b0, 3'd1, 16'h0008);
        rd_drv = 16'h0002;
        step();
        check_bus("rd_sts", 1'b1, 1'b1, 3'd0, 16'h0000);
        step();
        check_eq("rdcap_done", done, 1'b0);
        step();
        check_eq("idle_done", done, 1'b1);
        check_eq("idle_final", final_running, 1'b1);
        check_eq("idle_busy", busy, 1'b0);
        step();
        check_eq("done_pulse", done, 1'b0);
        wr_log.delete();

        // irq and stop together: CLR, RUN, then WR_STOP
        rd_drv = 16'h0000;
        launch(32'd3, 1'b1);
        irq_drv = 1'b1;
        stop    = 1'b1;
        step();
        irq_drv = 1'b0;
        stop    = 1'b0;
        check_eq("both_tick", tick, 1'b1);
        check_bus("both_clr", 1'b1, 1'b0, 3'd0, 16'h0000);
        step();
        check_eq("both_run_cs", bus.chipselect, 1'b0);
        step();
        check_bus("both_stop", 1'b1, 1'b0, 3'd1, 16'h0008);
        wait_done("both_done");
        check_eq("both_count", tick_count, 16'd1);
        check_eq("both_final", final_running, 1'b0);

        // stop during CLR is held pending
        launch(32'd3, 1'b1);
        irq_drv = 1'b1;
        step();
        irq_drv = 1'b0;
        stop    = 1'b1;
        step();
        stop = 1'b0;
        check_eq("pend_run_cs", bus.chipselect, 1'b0);
        step();
        check_bus("pend_stop", 1'b1, 1'b0, 3'd1, 16'h0008);
        wait_done("pend_done");

        // stop outside RUN and start while busy are ignored
        wr_log.delete();
        period     = 32'd5;
        continuous = 1'b1;
        start      = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b1;
        step();
        stop = 1'b0;
        step();
        step();
        step();
        check_eq("ign_stop_busy", busy, 1'b1);
        check_eq("ign_stop_cs", bus.chipselect, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check_eq("ign_start_writes", wr_log.size(), 3);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_bus("ign_wr_stop", 1'b1, 1'b0, 3'd1, 16'h0008);
        wait_done("ign_done");
        wr_log.delete();

        // All-ones period, single-shot, direct irq
        rd_drv = 16'h0002;
        launch(32'hFFFF_FFFF, 1'b0);
        irq_drv = 1'b1;
        step();
        irq_drv = 1'b0;
        step();
        check_bus("ss_stop", 1'b1, 1'b0, 3'd1, 16'h0008);
        wait_done("ss_done");
        check_eq("ss_final", final_running, 1'b1);
        exp_wr(3'd2, 16'hFFFF);
        exp_wr(3'd3, 16'hFFFF);
        exp_wr(3'd1, 16'h0005);
        exp_wr(3'd0, 16'h0000);
        exp_wr(3'd1, 16'h0008);
        compare_log("ss_log");

        // Reset during WR_PH
        rd_drv = 16'h0000;
        start  = 1'b1;
        step();
        start = 1'b0;
        step();
        reset = 1'b1;
        step();
        check_bus("rph", 1'b0, 1'b1, 3'd0, 16'h0000);
        check_eq("rph_busy", busy, 1'b0);
        check_eq("rph_final", final_running, 1'b0);
        reset = 1'b0;

        // Reset during RUN after one service
        launch(32'd7, 1'b1);
        irq_drv = 1'b1;
        step();
        irq_drv = 1'b0;
        step();
        check_eq("rrun_pre_count", tick_count, 16'd1);
        reset = 1'b1;
        step();
        check_eq("rrun_count", tick_count, 16'd0);
        check_eq("rrun_busy", busy, 1'b0);
        check_bus("rrun", 1'b0, 1'b1, 3'd0, 16'h0000);
        reset  = 1'b0;
        period = 32'd1;
        start  = 1'b1;
        step();
        start = 1'b0;
        check_bus("post_rst_start", 1'b1, 1'b0, 3'd2, 16'h0001);
        do_reset();
        wr_log.delete();
        tick_times.delete();

        // Slave model, single-shot, period 4
        use_model = 1'b1;
        launch(32'd4, 1'b0);
        wait_done("mss_done");
        check_eq("mss_final", final_running, 1'b0);
        check_eq("mss_count", tick_count, 16'd1);
        check_eq("mss_ticks", tick_times.size(), 1);
        exp_wr(3'd2, 16'h0004);
        exp_wr(3'd3, 16'h0000);
        exp_wr(3'd1, 16'h0005);
        exp_wr(3'd0, 16'h0000);
        exp_wr(3'd1, 16'h0008);
        compare_log("mss_log");
        tick_times.delete();

        // Slave model, continuous, period 9: timeout every 10 cycles
        launch(32'd9, 1'b1);
        for (int n = 0; n < 300 && tick_count != 16'd5; n++) step();
        check_eq("mc_count5", tick_count, 16'd5);
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_done("mc_done");
        check_eq("mc_count", tick_count, 16'd5);
        check_eq("mc_final", final_running, 1'b0);
        check_eq("mc_ticks", tick_times.size(), 5);
        for (int i = 1; i < tick_times.size(); i++) begin
            check_eq("mc_spacing", tick_times[i] - tick_times[i-1], 10);
        end
        exp_wr(3'd2, 16'h0009);
        exp_wr(3'd3, 16'h0000);
        exp_wr(3'd1, 16'h0007);
        for (int i = 0; i < 5; i++) exp_wr(3'd0, 16'h0000);
        exp_wr(3'd1, 16'h0008);
        compare_log("mc_log");
        use_model = 1'b0;

        // TICK_W=2 wrap
        period     = 32'd5;
        continuous = 1'b1;
        start2     = 1'b1;
        step();
        start2 = 1'b0;
        step();
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            irq2_drv = 1'b1;
            step();
            irq2_drv = 1'b0;
            check_eq("tw2_tick", tick2, 1'b1);
            check_eq("tw2_count", tick_count2, exp_tw2[i]);
            step();
        end
        stop2 = 1'b1;
        step();
        stop2 = 1'b0;
        begin
            bit seen2 = 1'b0;
            for (int n = 0; n < 20 && !seen2; n++) begin
                step();
                if (done2) seen2 = 1'b1;
            end
            check_eq("tw2_done", seen2, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
